// File: rtl/fetch_pc_unit.sv
// F-stage PC register, next-PC selection and IF/ID field generation.
// Optional FETCH_PERF_EN adds fetch/redirect event counters; otherwise the counter ports read 0.
module fetch_pc_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY  = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFF,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        d_is_bj,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic [4:0]  f_exccode,
  output logic        f_delay,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
);

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic        fetch_bad_s;
  logic        take_redirect_s;

  assign fetch_bad_s = (pc_r[1:0] != 2'b00) || (pc_r < IMEM_BASE) || (pc_r > IMEM_LIMIT);

  // eret bypasses stall: the hazard unit only lets eret through once epc is settled.
  always_comb begin
    next_pc_s       = pc_r + 32'd4;
    take_redirect_s = 1'b0;
    if (req) begin
      next_pc_s = EXC_ENTRY;
    end else if (eret) begin
      next_pc_s = epc;
    end else if (stall) begin
      next_pc_s = pc_r;
    end else if (redirect) begin
      next_pc_s       = redirect_target;
      take_redirect_s = 1'b1;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= PC_RESET;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Killed (eret) or faulting fetches hand a nop to decode.
  always_comb begin
    f_instr   = imem_rdata;
    f_exccode = 5'd0;
    if (eret) begin
      f_instr   = 32'd0;
      f_exccode = 5'd0;
    end else if (fetch_bad_s) begin
      f_instr   = 32'd0;
      f_exccode = EXC_ADEL;
    end else begin
      f_instr   = imem_rdata;
      f_exccode = 5'd0;
    end
  end

  assign f_pc      = pc_r;
  assign imem_addr = pc_r;
  assign f_delay   = d_is_bj & ~eret;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_r;
  logic [31:0] redirect_count_r;

  // Event counters; redirect only counts when that path actually wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_r    <= 32'd0;
      redirect_count_r <= 32'd0;
    end else begin
      if (!req && !stall && !fetch_bad_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      if (take_redirect_s) begin
        redirect_count_r <= redirect_count_r + 32'd1;
      end else begin
        redirect_count_r <= redirect_count_r;
      end
    end
  end

  assign fetch_count    = fetch_count_r;
  assign redirect_count = redirect_count_r;
`else
  logic unused_perf_s;
  assign unused_perf_s  = take_redirect_s;
  assign fetch_count    = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit plus hand sequences for reset and counters.
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        d_is_bj;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic [4:0]  f_exccode;
  logic        f_delay;
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .redirect(redirect), .redirect_target(redirect_target), .d_is_bj(d_is_bj),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .f_pc(f_pc), .f_instr(f_instr),
    .f_exccode(f_exccode), .f_delay(f_delay), .fetch_count(fetch_count),
    .redirect_count(redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic        eret;
    logic        redirect;
    logic        d_is_bj;
    logic [31:0] epc;
    logic [31:0] target;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [4:0]  exp_exc;
    logic        exp_delay;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; req = 1'b0; eret = 1'b0; redirect = 1'b0; d_is_bj = 1'b0;
    epc = 32'd0; redirect_target = 32'd0; imem_rdata = 32'hDEAD_BEEF;
  endtask

`ifdef FETCH_PERF_EN
  localparam logic [31:0] EXP_FETCHES   = 32'd8;
  localparam logic [31:0] EXP_REDIRECTS = 32'd1;
`else
  localparam logic [31:0] EXP_FETCHES   = 32'd0;
  localparam logic [31:0] EXP_REDIRECTS = 32'd0;
`endif

  initial begin
    //          S     R     E     D     B     epc           target        rdata         pc            instr         exc   delay
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0000, 32'h0000_3000, 32'hC0DE_0000, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0001, 32'h0000_3004, 32'hC0DE_0001, 5'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0002, 32'h0000_3008, 32'hC0DE_0002, 5'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0003, 32'h0000_300C, 32'hC0DE_0003, 5'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0004, 32'h0000_3010, 32'hC0DE_0004, 5'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0005, 32'h0000_3010, 32'hC0DE_0005, 5'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0006, 32'h0000_3010, 32'hC0DE_0006, 5'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0007, 32'h0000_3014, 32'hC0DE_0007, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0008, 32'h0000_3018, 32'hC0DE_0008, 5'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0009, 32'h0000_301C, 32'hC0DE_0009, 5'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_3100, 32'hC0DE_000A, 32'h0000_3020, 32'hC0DE_000A, 5'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_3102, 32'hC0DE_000B, 32'h0000_3100, 32'hC0DE_000B, 5'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_000C, 32'h0000_3102, 32'h0,          5'd4, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_3200, 32'hC0DE_000D, 32'h0000_4180, 32'hC0DE_000D, 5'd0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_3300, 32'hC0DE_000E, 32'h0000_3200, 32'hC0DE_000E, 5'd0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3204, 32'h0,        32'hC0DE_000F, 32'h0000_4180, 32'h0,          5'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_6FFC, 32'hC0DE_0010, 32'h0000_3204, 32'hC0DE_0010, 5'd0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0011, 32'h0000_6FFC, 32'hC0DE_0011, 5'd0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_2FFC, 32'hC0DE_0012, 32'h0000_7000, 32'h0,          5'd4, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFF_FFFC, 32'hC0DE_0013, 32'h0000_2FFC, 32'h0,          5'd4, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC0DE_0014, 32'hFFFF_FFFC, 32'h0,          5'd4, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_3008, 32'hC0DE_0015, 32'h0000_0000, 32'h0,          5'd4, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0,        32'hC0DE_0016, 32'h0000_0000, 32'h0,          5'd0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'hC0DE_0017, 32'h0000_3000, 32'hC0DE_0017, 5'd0, 1'b1};

    idle_inputs();
    reset = 1'b1;
    d_is_bj = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_pc", f_pc, 32'h0000_3000);
    check("reset_imem_addr", imem_addr, 32'h0000_3000);
    check("reset_exccode", {27'd0, f_exccode}, 32'd0);
    check("reset_delay", {31'd0, f_delay}, 32'd1);
    check("reset_fetch_count", fetch_count, 32'd0);
    check("reset_redirect_count", redirect_count, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].stall; req = vecs[i].req; eret = vecs[i].eret;
      redirect = vecs[i].redirect; d_is_bj = vecs[i].d_is_bj; epc = vecs[i].epc;
      redirect_target = vecs[i].target; imem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_pc", i), f_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].exp_pc);
      check($sformatf("v%0d_instr", i), f_instr, vecs[i].exp_instr);
      check($sformatf("v%0d_exccode", i), {27'd0, f_exccode}, {27'd0, vecs[i].exp_exc});
      check($sformatf("v%0d_delay", i), {31'd0, f_delay}, {31'd0, vecs[i].exp_delay});
      @(negedge clk);
    end

    // Reset asserted together with a redirect: reset must win.
    idle_inputs();
    redirect = 1'b1; redirect_target = 32'h0000_5000; reset = 1'b1;
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check("reset_vs_redirect_pc", f_pc, 32'h0000_3000);
    check("after_run_fetch_count_cleared", fetch_count, 32'd0);

    // Counter run: 10 cycles, 2 stalls, 1 redirect, all fetches legal.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("perf_start_fetch_count", fetch_count, 32'd0);
    check("perf_start_redirect_count", redirect_count, 32'd0);
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      stall = (c == 2 || c == 3);
      redirect = (c == 4);
      redirect_target = 32'h0000_3100;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("perf_fetch_count", fetch_count, EXP_FETCHES);
    check("perf_redirect_count", redirect_count, EXP_REDIRECTS);
    check("perf_pc", f_pc, 32'h0000_3114);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("perf_reset_fetch_count", fetch_count, 32'd0);
    check("perf_reset_redirect_count", redirect_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- F-stage producer for the IF/ID pipeline register.
- Owns the PC register and drives the instruction-memory address.
- Computes next PC from sequential flow, D-stage branch/jump redirect, eret return and exception entry.
- Produces the per-instruction fields the IF/ID register latches: pc, instr, EXCcode, delay-slot flag.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry PC.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_LIMIT, 32'h0000_6FFF, highest legal fetch byte address.
- EXC_ADEL, 5'd4, EXCcode for an instruction-fetch address error.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- stall  in  1  hazard stall; PC holds.
- req  in  1  exception/interrupt request from CP0.
- eret  in  1  D-stage instruction is eret.
- epc  in  32  eret return address from CP0.
- redirect  in  1  D-stage branch taken or jump.
- redirect_target  in  32  branch/jump target.
- d_is_bj  in  1  D-stage instruction is a branch/jump; the current F instruction is its delay slot.
- imem_addr  out  32  instruction-memory address; equals f_pc.
- imem_rdata  in  32  instruction word, combinational read.
- f_pc  out  32  current fetch PC.
- f_instr  out  32  instruction passed to IF/ID.
- f_exccode  out  5  0 or EXC_ADEL.
- f_delay  out  1  current F instruction is in a delay slot.

Behaviour:
- Single 32-bit PC register, updated on posedge clk. All other outputs are combinational from the PC register and the inputs.
- Update priority, highest first:
  - reset -> PC_RESET.
  - req -> EXC_ENTRY.
  - eret -> epc. Applied even if stall is high: eret stalls only on the epc hazard, which the hazard unit resolves before asserting eret-accept. eret is qualified upstream, so the block trusts it.
  - stall -> hold.
  - redirect -> redirect_target.
  - otherwise PC+4, 32-bit wraparound with no saturation.
- Reset outputs: f_pc=0x3000, f_exccode=0, f_delay=d_is_bj.
- Address check, where fetch_bad = (f_pc[1:0]!=0) or (f_pc<IMEM_BASE) or (f_pc>IMEM_LIMIT):
  - If fetch_bad: f_exccode=EXC_ADEL and f_instr=0 (nop), so bad data never decodes. imem_addr still equals f_pc; memory ignores it.
- eret kill: when eret=1, f_instr=0 and f_exccode=0 in the same cycle. No delay slot after eret.
- f_delay=d_is_bj, passed through for the victim's BD bit. Forced 0 when eret=1.
- req and redirect in the same cycle: req wins; redirect is discarded.
- req during stall: req wins.
- Reset mid-redirect: reset wins; the next cycle fetches 0x3000.
- Latency:
  - A redirect seen in cycle N fetches the target in cycle N+1.
  - The instruction fetched in cycle N (the delay slot) proceeds normally.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count[31:0], a register reset to 0.
  - Increments by 1 on every clock edge where reset=0, req=0, stall=0 and fetch_bad=0. Wraps at 2^32.
  - Adds output redirect_count[31:0], incremented on cycles where the PC update takes the redirect path.
- Undefined: the ports still exist, tied to 0; no counter flops are synthesised.

Test Plan:
- Reset then 3 free-running cycles -> f_pc sequence 0x3000, 0x3004, 0x3008, 0x300C; f_exccode=0 throughout.
- At f_pc=0x3010 assert stall for 2 cycles -> f_pc stays 0x3010 for 2 cycles, then 0x3014.
- At f_pc=0x3020, d_is_bj=1, redirect=1, target=0x3100 -> f_delay=1 at 0x3020; next f_pc=0x3100.
- redirect to 0x3102 -> f_exccode=4, f_instr=0 at f_pc=0x3102. Then req=1 -> next f_pc=0x4180, f_exccode=0.
- req=1 and redirect=1 at f_pc=0x3200 -> next f_pc=0x4180. Then eret=1 with epc=0x3204 and stall=1 -> f_instr=0 that cycle; next f_pc=0x3204.
- With FETCH_PERF_EN, 10 fetches including 2 stall cycles and 1 redirect -> fetch_count=8, redirect_count=1. Reset mid-run -> both counters 0 the next cycle.
